// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, the NOP encoding, the IF/ID entry layout
// and the instruction field layout that the decode stage also relies on.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] instr;
  } fd_entry_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

endpackage

// File: rtl/mips_fetch_stage_if.sv
// IF/ID boundary bundle plus the instruction-memory load port.
// Handshake: an entry transfers on a rising edge when fd_valid_o && !stall_i; stall_i is the
// inverse of ready. redirect_i overrides the transfer and discards everything in flight.
interface mips_fetch_stage_if #(
  parameter int IM_AW = 7
);
  logic             stall_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic             fd_valid_o;
  logic [31:0]      fd_pc_o;
  logic [31:0]      fd_instr_o;
  logic             imem_we_i;
  logic [IM_AW-1:0] imem_addr_i;
  logic [31:0]      imem_wdata_i;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_we_i, imem_addr_i, imem_wdata_i,
    output fd_valid_o, fd_pc_o, fd_instr_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_we_i, imem_addr_i, imem_wdata_i,
    input  fd_valid_o, fd_pc_o, fd_instr_o
  );
endinterface

// File: rtl/mips_fetch_stage_queue.sv
// Generic synchronous FIFO with flush and occupancy count. The head is kept in its own
// register so the consumer sees no combinational path from pop_i; it holds when empty.
module fetch_queue #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   count_o
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && valid_q;
    do_push  = push_i && ((count_q != FULL) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      // A sole surviving entry that was pushed this edge is still only on push_data_i.
      if (count_d != '0)
        head_d = (do_push && count_d == (AW+1)'(1)) ? push_data_i : mem_q[rd_ptr_d];
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign count_o = count_q;
endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS IF stage: PC, word-addressed instruction memory and push/pop gating around a
// prefetch queue that delivers {PC+4, instruction} to ID.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter int          IM_DEPTH = 128,
  parameter int          Q_DEPTH  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  mips_fetch_stage_if.master bus
);
  localparam int IW = $clog2(IM_DEPTH);
  localparam int CW = $clog2(Q_DEPTH) + 1;

  logic [WORD_W-1:0] instruction [0:IM_DEPTH-1];
  logic [31:0]       PC;

  logic [WORD_W-1:0] fetch_word;
  fd_entry_t         push_entry, head;
  logic [CW-1:0]     count;
  logic              q_valid, pop, room, push;

  // PC[1:0] never selects a word; the index wraps modulo IM_DEPTH.
  assign fetch_word = instruction[PC[IW+1:2]];
  assign pop        = q_valid && !bus.stall_i;
  assign room       = (count != CW'(Q_DEPTH)) || pop;
  assign push       = room && !bus.redirect_i;
  assign push_entry = '{pc4: PC + 32'd4, instr: fetch_word};

  always_ff @(posedge clk) begin
    if (!rst)                PC <= RESET_PC;
    else if (bus.redirect_i) PC <= bus.redirect_pc_i;
    else if (push)           PC <= PC + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (bus.imem_we_i) instruction[bus.imem_addr_i] <= bus.imem_wdata_i;
  end

  fetch_queue #(
    .DEPTH (Q_DEPTH),
    .W     ($bits(fd_entry_t))
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .valid_o     (q_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.fd_valid_o = q_valid;
  assign bus.fd_pc_o    = head.pc4;
  assign bus.fd_instr_o = q_valid ? head.instr : NOP;
endmodule
